// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and defaults for the sequence serializer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_SEQ_W = 16;
  localparam logic [15:0] DEFAULT_SEQ = 16'b0010001110110010;
endpackage

// File: rtl/seq_serializer.sv
// seq_serializer: plays a captured sequence word LSB first, one bit per consumer step
module seq_serializer
  import seq_pkg::*;
#(
  parameter int SEQ_W = DEFAULT_SEQ_W,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic             repeat_en,
  input  logic             step,
  output logic             inp,
  output logic             bit_valid,
  output logic [IDX_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);
  state_t state, state_n;
  logic [SEQ_W-1:0] shift_reg, saved;
  logic last;
  assign last = bit_idx == IDX_W'(SEQ_W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift_reg <= '0;
      saved <= '0;
      bit_idx <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && load) begin
        shift_reg <= seq_in;
        saved <= seq_in;
        bit_idx <= '0;
      end else if (state == SHIFT && step) begin
        shift_reg <= last ? (repeat_en ? saved : shift_reg) : shift_reg >> 1;
        bit_idx <= last ? '0 : bit_idx + 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (load ? SHIFT : IDLE) :
              state == SHIFT ? ((step && last && !repeat_en) ? DONE : SHIFT) :
              IDLE;
  end
  always_comb begin
    busy = state == SHIFT;
    bit_valid = state == SHIFT;
    inp = (state == SHIFT) & shift_reg[0];
    done = state == DONE;
  end
endmodule
